// File: rtl/sorted_word_serializer_if.sv
// sorted_word_serializer_if: sorter vector in, word stream out, plus status and overflow clear.
interface sorted_word_serializer_if #(parameter int BITWIDTH = 8);
  logic [8*BITWIDTH:0] din;
  logic                clr_ovf;
  logic [BITWIDTH-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  logic [2:0]          dout_index;
  logic                dout_last;
  logic                busy;
  logic                overflow;
  modport slave (input din, clr_ovf, dout_ready,
                 output dout, dout_valid, dout_index, dout_last, busy, overflow);
  modport master (output din, clr_ovf, dout_ready,
                  input dout, dout_valid, dout_index, dout_last, busy, overflow);
endinterface

// File: rtl/sorted_word_serializer.sv
// sorted_word_serializer: detects new sorter results, buffers two, streams them word 0 first.
module sorted_word_serializer #(
  parameter int BITWIDTH = 8
) (
  input logic clk,
  input logic reset,
  sorted_word_serializer_if.slave bus
);
  localparam int W = 8*BITWIDTH;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [W-1:0] act, act_n, pend, pend_n, last_seen, din_d;
  logic [2:0] idx, idx_n;
  logic pend_full, pend_full_n, prev_valid, ovf_n, din_v, evt, xfer, last_beat;
  assign din_d = bus.din[W-1:0];
  assign din_v = bus.din[W];
  assign evt = din_v && (!prev_valid || din_d != last_seen);
  assign xfer = state == SEND && bus.dout_ready;
  assign last_beat = xfer && idx == 3'd7;
  assign bus.busy = state == SEND || pend_full;
  always_comb begin
    state_n = state;
    act_n = act;
    pend_n = pend;
    pend_full_n = pend_full;
    idx_n = idx;
    ovf_n = bus.overflow && !bus.clr_ovf;
    if (state == IDLE) begin
      if (evt) begin
        act_n = din_d;
        idx_n = 3'd0;
        state_n = SEND;
      end
    end else begin
      if (xfer && idx != 3'd7) idx_n = idx + 3'd1;
      else if (last_beat && pend_full) begin
        act_n = pend;
        idx_n = 3'd0;
        pend_full_n = 1'b0;
      end else if (last_beat && evt) begin
        act_n = din_d;
        idx_n = 3'd0;
      end else if (last_beat) state_n = IDLE;
      // an evt that lands on the final beat with pending empty was already taken into active
      if (evt && !(last_beat && !pend_full)) begin
        if (!pend_full || last_beat) begin
          pend_n = din_d;
          pend_full_n = 1'b1;
        end else ovf_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      act <= '0;
      pend <= '0;
      pend_full <= 1'b0;
      idx <= 3'd0;
      prev_valid <= 1'b0;
      last_seen <= '0;
      bus.overflow <= 1'b0;
      bus.dout <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_index <= 3'd0;
      bus.dout_last <= 1'b0;
    end else begin
      state <= state_n;
      act <= act_n;
      pend <= pend_n;
      pend_full <= pend_full_n;
      idx <= idx_n;
      prev_valid <= din_v;
      if (din_v) last_seen <= din_d;
      bus.overflow <= ovf_n;
      bus.dout_valid <= state_n == SEND;
      if (state_n == SEND) begin
        bus.dout <= act_n[idx_n*BITWIDTH +: BITWIDTH];
        bus.dout_index <= idx_n;
        bus.dout_last <= idx_n == 3'd7;
      end
    end
  end
endmodule

// File: tb/tb_sorted_word_serializer.sv
// tb_sorted_word_serializer: directed and random stimulus against a word-count scoreboard model.
module tb_sorted_word_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  sorted_word_serializer_if #(.BITWIDTH(8)) bus();
  sorted_word_serializer #(.BITWIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // model: words outstanding inside the DUT; at most two vectors may be held
  logic [10:0] exp_q[$];
  int m_out = 0;
  logic m_ovf = 1'b0;
  logic m_prev = 1'b0;
  logic [63:0] m_last = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_out = 0;
      m_ovf = 1'b0;
      m_prev = 1'b0;
      m_last = '0;
    end else begin
      logic v, evt, drop;
      logic [63:0] d;
      int o2;
      v = bus.din[64];
      d = bus.din[63:0];
      evt = v && (!m_prev || d != m_last);
      o2 = m_out - ((m_out > 0 && bus.dout_ready) ? 1 : 0);
      drop = 1'b0;
      if (evt) begin
        if (o2 <= 8) begin
          o2 += 8;
          for (int k = 0; k < 8; k++) exp_q.push_back({k[2:0], d[k*8 +: 8]});
        end else drop = 1'b1;
      end
      m_ovf = (m_ovf && !bus.clr_ovf) || drop;
      m_prev = v;
      if (v) m_last = d;
      m_out = o2;
    end
  end

  logic prev_stall = 1'b0;
  logic [7:0] prev_dout;
  logic [2:0] prev_idx;
  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      chk("dout_valid", {31'd0, bus.dout_valid}, {31'd0, m_out > 0});
      chk("busy", {31'd0, bus.busy}, {31'd0, m_out > 0});
      chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
      if (prev_stall) begin
        chk("stall_dout", {24'd0, bus.dout}, {24'd0, prev_dout});
        chk("stall_index", {29'd0, bus.dout_index}, {29'd0, prev_idx});
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {24'd0, bus.dout}, 32'hffff_ffff);
        else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          chk("dout", {24'd0, bus.dout}, {24'd0, e[7:0]});
          chk("dout_index", {29'd0, bus.dout_index}, {29'd0, e[10:8]});
          chk("dout_last", {31'd0, bus.dout_last}, {31'd0, e[10:8] == 3'd7});
        end
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout = bus.dout;
      prev_idx = bus.dout_index;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, {24'd0, bus.dout}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.dout_valid}, 32'd0);
    chk({tag, "_index"}, {29'd0, bus.dout_index}, 32'd0);
    chk({tag, "_last"}, {31'd0, bus.dout_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, bus.overflow}, 32'd0);
  endtask

  localparam logic [64:0] VEC_A = {1'b1, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
  localparam logic [64:0] VEC_5 = {1'b1, {8{8'd5}}};
  localparam logic [64:0] VEC_B = {1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  localparam logic [64:0] VEC_C = {1'b1, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};

  initial begin
    logic [64:0] pool [4];
    bus.din = '0;
    bus.clr_ovf = 1'b0;
    bus.dout_ready = 1'b0;
    #2 chk_reset_outputs("reset");
    step(2);
    reset = 1'b0;
    step(2);
    // basic stream, then hold the vector: no repeat
    bus.dout_ready = 1'b1;
    bus.din = VEC_A;
    step(20);
    // backpressure: drop valid so the same vector yields a rising-edge evt
    bus.din[64] = 1'b0;
    step(1);
    bus.din = VEC_A;
    for (int i = 0; i < 30; i++) begin
      bus.dout_ready = (i % 3) == 0;
      step(1);
    end
    bus.dout_ready = 1'b1;
    step(10);
    // back-to-back: second vector arrives mid-stream
    bus.din = VEC_B;
    step(3);
    bus.din = VEC_5;
    step(20);
    // overflow: three vectors with the consumer stalled
    bus.dout_ready = 1'b0;
    bus.din = VEC_A;
    step(2);
    bus.din = VEC_B;
    step(2);
    bus.din = VEC_C;
    step(2);
    bus.dout_ready = 1'b1;
    step(20);
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    step(2);
    // reset mid-stream, din left valid and unchanged
    bus.din = VEC_A;
    step(5);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("async_reset");
    step(1);
    reset = 1'b0;
    step(15);
    // random phase
    for (int k = 0; k < 4; k++) pool[k] = {1'b1, $urandom(), $urandom()};
    for (int i = 0; i < 3000; i++) begin
      bus.dout_ready = $urandom_range(0, 3) != 0;
      bus.clr_ovf = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 5) == 0) begin
        bus.din = pool[$urandom_range(0, 3)];
        bus.din[64] = $urandom_range(0, 4) != 0;
      end
      step(1);
    end
    bus.din[64] = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.dout_ready = 1'b1;
    step(24);
    chk("drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
